// File: rtl/onehot_read_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : onehot_read_pkg
//  Purpose  : Shared types, defaults and helpers for onehot_read_arbiter.
//             - state_e     : controller state (bank empty / bank ready)
//             - onehot_dec  : address -> one-hot entry select, zero when the
//                             address is outside the bank
//  Macros   : none
//  Revision : 1.0  initial release
// ============================================================================
package onehot_read_pkg;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam int DEF_NUM_REQ     = 2;
  localparam int DEF_NUM_ENTRIES = 2;
  localparam int DEF_DATA_W      = 1;

  // Upper bound on bank depth handled by onehot_dec; callers cast the
  // result down to their own NUM_ENTRIES width.
  localparam int MAX_ENTRIES = 256;

  function automatic logic [MAX_ENTRIES-1:0] onehot_dec(input logic [31:0] addr,
                                                        input int unsigned n);
    logic [MAX_ENTRIES-1:0] sel;
    sel = '0;
    if ((addr < n) && (addr < 32'(MAX_ENTRIES))) begin
      sel[addr[7:0]] = 1'b1;
    end
    return sel;
  endfunction

endpackage : onehot_read_pkg
`default_nettype wire

// File: rtl/onehot_read_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : onehot_read_arbiter_if
//  Purpose  : Bus bundle between the requesters/loader and the arbiter.
//  Signals  : load, load_data  - bulk bank load strobe and contents
//             req, addr        - per-requester read request and address
//             gnt              - one-hot grant (same cycle as request)
//             rvalid, rdata    - one-hot read valid and read data (t+1)
//             ready            - bank loaded and arbitration active
//  Modports : master (requester side), slave (arbiter side)
//  Macros   : none
//  Revision : 1.0  initial release
// ============================================================================
interface onehot_read_arbiter_if #(
  parameter int NUM_REQ     = 2,
  parameter int NUM_ENTRIES = 2,
  parameter int DATA_W      = 1
);
  localparam int AW = (NUM_ENTRIES > 2) ? $clog2(NUM_ENTRIES) : 1;

  logic                          load;
  logic [NUM_ENTRIES*DATA_W-1:0] load_data;
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*AW-1:0]         addr;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            rvalid;
  logic [DATA_W-1:0]             rdata;
  logic                          ready;

  modport master (
    output load, load_data, req, addr,
    input  gnt, rvalid, rdata, ready
  );

  modport slave (
    input  load, load_data, req, addr,
    output gnt, rvalid, rdata, ready
  );

endinterface : onehot_read_arbiter_if
`default_nettype wire

// File: rtl/onehot_read_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Combinational round-robin pick. Scans req starting at ptr,
//             wrapping, and reports the first set bit as a one-hot grant
//             plus its index. All-zero grant when disabled or idle.
//  Ports    : req    in  NUM_REQ  request vector
//             ptr    in  IW       scan start index (register lives in parent)
//             enable in  1        arbitration allowed this cycle
//             gnt    out NUM_REQ  one-hot grant
//             idx    out IW       winner index (0 when no grant)
//  Macros   : none
//  Revision : 1.0  initial release
// ============================================================================
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int IW     = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx
);

  logic          w_found;
  logic [IW-1:0] w_cand;

  always_comb begin
    gnt     = '0;
    idx     = '0;
    w_found = 1'b0;
    w_cand  = '0;
    if (enable) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        w_cand = IW'((32'(ptr) + 32'(i)) % 32'(NUM_REQ));
        if (!w_found && req[w_cand]) begin
          gnt[w_cand] = 1'b1;
          idx         = w_cand;
          w_found     = 1'b1;
        end
      end
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/onehot_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : onehot_read_arbiter
//  Purpose  : Shares one read port of a small register bank between NUM_REQ
//             requesters with round-robin arbitration. The read port is a
//             registered one-hot select driving an AND-OR mux, so no two
//             entries are ever combined. Nothing is served before the first
//             bulk load.
//  Ports    : clk_i   in  1  clock, rising edge
//             rst_ni  in  1  synchronous active-low reset
//             bus     slave modport of onehot_read_arbiter_if
//  Macros   : ONEHOT_READ_SELECT_CLEAR_EN - when defined, the entry select
//             is cleared in every cycle without a grant, so rdata reads 0
//             whenever rvalid is low. Otherwise the last select is held.
//  Revision : 1.0  initial release
// ============================================================================
module onehot_read_arbiter
  import onehot_read_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int NUM_ENTRIES = DEF_NUM_ENTRIES,
  parameter int DATA_W      = DEF_DATA_W
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  onehot_read_arbiter_if.slave  bus
);

  localparam int AW = (NUM_ENTRIES > 2) ? $clog2(NUM_ENTRIES) : 1;
  localparam int IW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

  localparam logic [0:0] S_EMPTY = ST_EMPTY;
  localparam logic [0:0] S_READY = ST_READY;

  logic [0:0]                    r_state;
  logic [NUM_ENTRIES*DATA_W-1:0] r_bank;
  logic [NUM_ENTRIES-1:0]        r_oh_sel;
  logic [IW-1:0]                 r_rr_ptr;
  logic [NUM_REQ-1:0]            r_rvalid;

  logic                   w_arb_en;
  logic [NUM_REQ-1:0]     w_gnt;
  logic [IW-1:0]          w_win;
  logic                   w_grant;
  logic [AW-1:0]          w_addr_k;
  logic [NUM_ENTRIES-1:0] w_sel_next;
  logic [NUM_ENTRIES-1:0] w_sel_idle;
  logic [IW-1:0]          w_ptr_next;
  logic [DATA_W-1:0]      w_rdata;

  // A load in READY takes the cycle: no grant, bank is rewritten instead.
  assign w_arb_en = (r_state == S_READY) & ~bus.load;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req    (bus.req),
    .ptr    (r_rr_ptr),
    .enable (w_arb_en),
    .gnt    (w_gnt),
    .idx    (w_win)
  );

  assign w_grant    = |w_gnt;
  assign w_addr_k   = bus.addr[w_win*AW +: AW];
  assign w_sel_next = NUM_ENTRIES'(onehot_dec(32'(w_addr_k), NUM_ENTRIES));
  assign w_ptr_next = (w_win == IW'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;

`ifdef ONEHOT_READ_SELECT_CLEAR_EN
  assign w_sel_idle = '0;
`else
  assign w_sel_idle = r_oh_sel;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state  <= S_EMPTY;
      r_bank   <= '0;
      r_oh_sel <= '0;
      r_rr_ptr <= '0;
      r_rvalid <= '0;
    end else begin
      r_rvalid <= w_gnt;
      r_oh_sel <= w_grant ? w_sel_next : w_sel_idle;
      if (w_grant) begin
        r_rr_ptr <= w_ptr_next;
      end
      if (bus.load) begin
        r_bank  <= bus.load_data;
        r_state <= S_READY;
      end
    end
  end

  // AND-OR mux; r_oh_sel is one-hot or zero, so at most one entry passes.
  always_comb begin
    w_rdata = '0;
    for (int e = 0; e < NUM_ENTRIES; e++) begin
      w_rdata = w_rdata | (r_bank[e*DATA_W +: DATA_W] & {DATA_W{r_oh_sel[e]}});
    end
  end

  assign bus.gnt    = w_gnt;
  assign bus.rvalid = r_rvalid;
  assign bus.rdata  = w_rdata;
  assign bus.ready  = (r_state == S_READY) & ~bus.load;

endmodule : onehot_read_arbiter
`default_nettype wire

// File: tb/tb_onehot_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_onehot_read_arbiter
//  Purpose  : Directed self-checking bench for onehot_read_arbiter with the
//             default 2-requester, 2-entry, 1-bit configuration.
//  Macros   : ONEHOT_READ_SELECT_CLEAR_EN - selects the idle rdata expectation
//  Revision : 1.0  initial release
// ============================================================================
module tb_onehot_read_arbiter;

  logic clk;
  logic rst_n;

  int n_pass;
  int n_total;

  onehot_read_arbiter_if #(.NUM_REQ(2), .NUM_ENTRIES(2), .DATA_W(1)) bus ();

  onehot_read_arbiter #(
    .NUM_REQ     (2),
    .NUM_ENTRIES (2),
    .DATA_W      (1)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic exp_idle_rdata;

  initial begin
    n_pass  = 0;
    n_total = 0;
`ifdef ONEHOT_READ_SELECT_CLEAR_EN
    exp_idle_rdata = 1'b0;
`else
    exp_idle_rdata = 1'b1;
`endif

    rst_n         = 1'b0;
    bus.load      = 1'b0;
    bus.load_data = 2'b00;
    bus.req       = 2'b00;
    bus.addr      = 2'b00;
    tick();
    tick();

    // Reset state
    chk("rst_gnt",    32'(bus.gnt),    32'h0);
    chk("rst_rvalid", 32'(bus.rvalid), 32'h0);
    chk("rst_rdata",  32'(bus.rdata),  32'h0);
    chk("rst_ready",  32'(bus.ready),  32'h0);

    // Bring-up: requests before first load are ignored
    rst_n   = 1'b1;
    bus.req = 2'b11;
    #1;
    chk("empty_gnt",   32'(bus.gnt),   32'h0);
    chk("empty_ready", 32'(bus.ready), 32'h0);
    tick();
    chk("empty_rvalid", 32'(bus.rvalid), 32'h0);

    // First load
    bus.req       = 2'b00;
    bus.load      = 1'b1;
    bus.load_data = 2'b10;
    #1;
    chk("load_ready_low", 32'(bus.ready), 32'h0);
    tick();
    bus.load = 1'b0;
    #1;
    chk("loaded_ready", 32'(bus.ready), 32'h1);

    // Single read: requester 0, entry 1 (=1)
    bus.req  = 2'b01;
    bus.addr = 2'b01;
    #1;
    chk("rd0_gnt", 32'(bus.gnt), 32'h1);
    tick();
    chk("rd0_rvalid", 32'(bus.rvalid), 32'h1);
    chk("rd0_rdata",  32'(bus.rdata),  32'h1);

    // Requester 0 again, entry 0 (=0); pointer is 1, wraps to 0
    bus.addr = 2'b00;
    #1;
    chk("rd1_gnt", 32'(bus.gnt), 32'h1);
    tick();
    chk("rd1_rvalid", 32'(bus.rvalid), 32'h1);
    chk("rd1_rdata",  32'(bus.rdata),  32'h0);

    // Requester 1, entry 1; pointer returns to 0 afterwards
    bus.req  = 2'b10;
    bus.addr = 2'b10;
    #1;
    chk("rd2_gnt", 32'(bus.gnt), 32'h2);
    tick();
    chk("rd2_rvalid", 32'(bus.rvalid), 32'h2);
    chk("rd2_rdata",  32'(bus.rdata),  32'h1);

    // Round robin: both requesting, req0 -> entry 0, req1 -> entry 1
    bus.req  = 2'b11;
    bus.addr = 2'b10;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr%0d_gnt", i), 32'(bus.gnt), (i % 2 == 0) ? 32'h1 : 32'h2);
      tick();
      chk($sformatf("rr%0d_rvalid", i), 32'(bus.rvalid), (i % 2 == 0) ? 32'h1 : 32'h2);
      chk($sformatf("rr%0d_rdata", i),  32'(bus.rdata),  32'(i % 2));
    end

    // Load collision: load wins, in-flight read still sees old bank
    bus.req       = 2'b01;
    bus.addr      = 2'b00;
    bus.load      = 1'b1;
    bus.load_data = 2'b01;
    #1;
    chk("coll_gnt",       32'(bus.gnt),   32'h0);
    chk("coll_ready",     32'(bus.ready), 32'h0);
    chk("coll_old_rdata", 32'(bus.rdata), 32'h1);
    tick();
    chk("coll_rvalid", 32'(bus.rvalid), 32'h0);
    bus.load = 1'b0;
    #1;
    chk("post_load_gnt", 32'(bus.gnt), 32'h1);
    tick();
    chk("post_load_rvalid", 32'(bus.rvalid), 32'h1);
    chk("post_load_rdata",  32'(bus.rdata),  32'h1);

    // Reset mid-read: grant now, reset at the next edge
    #1;
    chk("midrst_gnt", 32'(bus.gnt), 32'h1);
    rst_n = 1'b0;
    tick();
    chk("midrst_rvalid", 32'(bus.rvalid), 32'h0);
    chk("midrst_rdata",  32'(bus.rdata),  32'h0);
    chk("midrst_ready",  32'(bus.ready),  32'h0);
    chk("midrst_gnt0",   32'(bus.gnt),    32'h0);

    // Reload, read entry 1 via requester 1, then go idle
    rst_n         = 1'b1;
    bus.req       = 2'b00;
    bus.load      = 1'b1;
    bus.load_data = 2'b10;
    tick();
    bus.load = 1'b0;
    bus.req  = 2'b10;
    bus.addr = 2'b10;
    #1;
    chk("idle_rd_gnt", 32'(bus.gnt), 32'h2);
    tick();
    chk("idle_rd_rdata", 32'(bus.rdata), 32'h1);
    bus.req = 2'b00;
    tick();
    chk("idle_rvalid", 32'(bus.rvalid), 32'h0);
    chk("idle_rdata",  32'(bus.rdata),  32'(exp_idle_rdata));
    chk("idle_ready",  32'(bus.ready),  32'h1);

    // Pointer unchanged by idle cycle: it was 0 after requester 1's grant
    bus.req  = 2'b11;
    bus.addr = 2'b10;
    #1;
    chk("ptr_hold_gnt", 32'(bus.gnt), 32'h1);
    tick();
    chk("ptr_hold_rdata", 32'(bus.rdata), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_onehot_read_arbiter
`default_nettype wire
